link_health_monitor: RTL and testbench

LINK_HEALTH_MONITOR -- requirements
Module: link_health_monitor

---
 rtl/link_health_monitor.sv | 165 ++++++++++++++++
 tb/tb_link_health_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/link_health_monitor.sv
// link_health_monitor: qualifies a PHY link and watches it for loss of signal, idle and error faults.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   sig_det      in   raw PHY signal-detect (asynchronous, synchronized here)
//   rx_valid     in   one cycle per received word
//   rx_err       in   one cycle per receive error
//   link_ok      out  1 while the link is UP
//   fault_code   out  cause of the last fault: 0 none, 1 LOS, 2 IDLE, 3 ERR
//   fault_pulse  out  one-cycle pulse on entry to FAULT
//   fault_count  out  saturating count of FAULT entries
//
// All timing parameters must lie in 1..2^24-1.
module link_health_monitor #(
    parameter int unsigned UP_TIME     = 1_000_000,
    parameter int unsigned ACT_TIMEOUT = 4_000_000,
    parameter int unsigned ERR_WINDOW  = 1_000_000,
    parameter int unsigned ERR_LIMIT   = 16,
    parameter int unsigned HOLD_TIME   = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_det,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       link_ok,
    output logic [1:0] fault_code,
    output logic       fault_pulse,
    output logic [7:0] fault_count
);
    typedef enum logic [1:0] {DOWN, QUALIFY, UP, FAULT} state_t;

    localparam logic [23:0] UP_LAST   = 24'(UP_TIME - 1);
    localparam logic [23:0] ACT_LAST  = 24'(ACT_TIMEOUT - 1);
    localparam logic [23:0] WIN_LAST  = 24'(ERR_WINDOW - 1);
    localparam logic [23:0] HOLD_LAST = 24'(HOLD_TIME - 1);
    localparam logic [24:0] ERR_LIM   = 25'(ERR_LIMIT);

    state_t      state_q, state_d;
    logic        sync1_q, sig_s_q;
    logic [23:0] qual_q, qual_d, hold_q, hold_d, idle_q, idle_d;
    logic [23:0] win_q, win_d, err_q, err_d;
    logic        seen_q, seen_d;
    logic        link_ok_q, link_ok_d, pulse_q, pulse_d;
    logic [1:0]  code_q, code_d, new_code;
    logic [7:0]  count_q, count_d;
    logic        go_up, go_fault, err_hit, idle_hit;

    always_comb begin
        state_d  = state_q;
        qual_d   = qual_q;
        seen_d   = seen_q;
        hold_d   = hold_q;
        idle_d   = idle_q;
        win_d    = win_q;
        err_d    = err_q;
        code_d   = code_q;
        count_d  = count_q;
        go_up    = 1'b0;
        go_fault = 1'b0;
        new_code = 2'd0;
        // The error sum is checked before the window wrap clears it, so an
        // error on the wrap cycle still belongs to the old window.
        err_hit  = ({1'b0, err_q} + {24'd0, rx_err}) == ERR_LIM;
        idle_hit = !rx_valid && idle_q == ACT_LAST;
        case (state_q)
            DOWN: begin
                if (sig_s_q) begin
                    state_d = QUALIFY;
                    qual_d  = 24'd0;
                    seen_d  = 1'b0;
                end
            end
            QUALIFY: begin
                if (!sig_s_q) begin
                    state_d = DOWN;
                end else if (rx_err) begin
                    qual_d = 24'd0;
                    seen_d = 1'b0;
                end else begin
                    qual_d = qual_q + 24'd1;
                    seen_d = seen_q | rx_valid;
                    if (qual_q == UP_LAST) begin
                        go_up    = seen_q | rx_valid;
                        go_fault = !(seen_q | rx_valid);
                        new_code = 2'd2;
                    end
                end
            end
            UP: begin
                if (!sig_s_q) begin
                    go_fault = 1'b1;
                    new_code = 2'd1;
                end else if (err_hit) begin
                    go_fault = 1'b1;
                    new_code = 2'd3;
                end else if (idle_hit) begin
                    go_fault = 1'b1;
                    new_code = 2'd2;
                end else begin
                    idle_d = rx_valid ? 24'd0 : idle_q + 24'd1;
                    win_d  = (win_q == WIN_LAST) ? 24'd0 : win_q + 24'd1;
                    err_d  = (win_q == WIN_LAST) ? {23'd0, rx_err} : err_q + {23'd0, rx_err};
                end
            end
            default: begin
                hold_d = hold_q + 24'd1;
                if (hold_q == HOLD_LAST) state_d = DOWN;
            end
        endcase
        if (go_up) begin
            state_d = UP;
            code_d  = 2'd0;
            idle_d  = 24'd0;
            win_d   = 24'd0;
            err_d   = 24'd0;
        end
        if (go_fault) begin
            state_d = FAULT;
            code_d  = new_code;
            hold_d  = 24'd0;
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end
        pulse_d   = go_fault;
        link_ok_d = state_d == UP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DOWN;
            sync1_q   <= 1'b0;
            sig_s_q   <= 1'b0;
            qual_q    <= 24'd0;
            seen_q    <= 1'b0;
            hold_q    <= 24'd0;
            idle_q    <= 24'd0;
            win_q     <= 24'd0;
            err_q     <= 24'd0;
            link_ok_q <= 1'b0;
            code_q    <= 2'd0;
            pulse_q   <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sig_det;
            sig_s_q   <= sync1_q;
            qual_q    <= qual_d;
            seen_q    <= seen_d;
            hold_q    <= hold_d;
            idle_q    <= idle_d;
            win_q     <= win_d;
            err_q     <= err_d;
            link_ok_q <= link_ok_d;
            code_q    <= code_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
        end
    end

    assign link_ok     = link_ok_q;
    assign fault_code  = code_q;
    assign fault_pulse = pulse_q;
    assign fault_count = count_q;
endmodule

// File: tb/tb_link_health_monitor.sv
// tb_link_health_monitor: directed self-checking bench for link_health_monitor.
module tb_link_health_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig_det = 1'b0, rx_valid = 1'b0, rx_err = 1'b0;
    logic       link_ok, fault_pulse;
    logic [1:0] fault_code;
    logic [7:0] fault_count;
    int         checks = 0, errors = 0;

    link_health_monitor #(
        .UP_TIME(8), .ACT_TIMEOUT(16), .ERR_WINDOW(32), .ERR_LIMIT(3), .HOLD_TIME(4)
    ) dut (
        .clk(clk), .rst(rst), .sig_det(sig_det), .rx_valid(rx_valid), .rx_err(rx_err),
        .link_ok(link_ok), .fault_code(fault_code), .fault_pulse(fault_pulse),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic sd, input logic v, input logic e);
        sig_det = sd;
        rx_valid = v;
        rx_err = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic bring_up();
        for (int i = 1; i <= 11; i++) cyc(1, 1, 0);
    endtask

    initial begin
        int np;
        do_reset();
        check("rst_link", link_ok, 0);
        check("rst_code", fault_code, 0);
        check("rst_pulse", fault_pulse, 0);
        check("rst_count", fault_count, 0);
        rst = 1'b0;

        for (int i = 1; i <= 11; i++) begin
            cyc(1, i % 4 == 0, 0);
            if (i == 10) check("qual_not_up_10", link_ok, 0);
        end
        check("up_at_11", link_ok, 1);
        check("up_code", fault_code, 0);

        // loss of signal while UP
        cyc(0, 1, 0);
        check("los_link_1", link_ok, 1);
        cyc(0, 1, 0);
        check("los_link_2", link_ok, 1);
        cyc(0, 1, 0);
        check("los_link_3", link_ok, 0);
        check("los_pulse", fault_pulse, 1);
        check("los_code", fault_code, 1);
        check("los_count", fault_count, 1);
        for (int j = 1; j <= 13; j++) begin
            cyc(1, 1, 0);
            if (j == 1) check("los_pulse_1cyc", fault_pulse, 0);
            if (j == 12) begin
                check("hold_requal_link", link_ok, 0);
                check("code_persists", fault_code, 1);
            end
        end
        check("requal_link", link_ok, 1);
        check("requal_code", fault_code, 0);
        check("requal_count", fault_count, 1);

        // idle timeout
        do_reset();
        bring_up();
        for (int i = 1; i <= 15; i++) cyc(1, 0, 0);
        cyc(1, 1, 0);
        check("idle15_ok", link_ok, 1);
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0, 0);
            if (i == 15) check("idle_before_16", link_ok, 1);
        end
        check("idle_link", link_ok, 0);
        check("idle_code", fault_code, 2);
        check("idle_pulse", fault_pulse, 1);

        // three errors inside one window
        do_reset();
        bring_up();
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 1, i == 1 || i == 5 || i == 9);
            if (i == 8) check("err_before", link_ok, 1);
        end
        check("err_link", link_ok, 0);
        check("err_code", fault_code, 3);

        // two errors, window wrap, one more: no fault
        do_reset();
        bring_up();
        for (int i = 1; i <= 40; i++) cyc(1, 1, i == 10 || i == 20 || i == 33);
        check("err_split_ok", link_ok, 1);

        // third error on the wrap cycle still counts
        do_reset();
        bring_up();
        for (int i = 1; i <= 32; i++) begin
            cyc(1, 1, i == 10 || i == 20 || i == 32);
            if (i == 31) check("wrap_before", link_ok, 1);
        end
        check("wrap_link", link_ok, 0);
        check("wrap_code", fault_code, 3);

        // error in QUALIFY restarts qualification
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            cyc(1, 1, i == 9);
            if (i == 11) check("qerr_not_11", link_ok, 0);
            if (i == 16) check("qerr_not_16", link_ok, 0);
        end
        check("qerr_up_17", link_ok, 1);

        // no activity during QUALIFY
        do_reset();
        for (int i = 1; i <= 11; i++) begin
            cyc(1, 0, 0);
            if (i == 10) check("qidle_pulse_10", fault_pulse, 0);
        end
        check("qidle_link", link_ok, 0);
        check("qidle_pulse", fault_pulse, 1);
        check("qidle_code", fault_code, 2);
        check("qidle_count", fault_count, 1);

        // activity only on the final qualify cycle
        do_reset();
        for (int i = 1; i <= 11; i++) cyc(1, i == 11, 0);
        check("qlast_valid_up", link_ok, 1);

        // LOS and third error on the same cycle
        do_reset();
        bring_up();
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        check("prio_before", link_ok, 1);
        cyc(0, 1, 1);
        check("prio_link", link_ok, 0);
        check("prio_code", fault_code, 1);

        // fault counter saturation
        do_reset();
        np = 0;
        for (int i = 0; i < 5000 && np < 256; i++) begin
            cyc(1, 0, 0);
            if (fault_pulse) begin
                np++;
                if (np == 254) check("sat_254", fault_count, 254);
                if (np == 255) check("sat_255", fault_count, 255);
                if (np == 256) check("sat_256", fault_count, 255);
            end
        end
        check("sat_pulses", np, 256);

        // asynchronous reset while UP
        do_reset();
        for (int i = 1; i <= 11; i++) cyc(1, 0, 0);
        for (int i = 1; i <= 13; i++) cyc(1, 1, 0);
        check("pre_rst_link", link_ok, 1);
        check("pre_rst_count", fault_count, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_link", link_ok, 0);
        check("arst_code", fault_code, 0);
        check("arst_pulse", fault_pulse, 0);
        check("arst_count", fault_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            cyc(1, 1, 0);
            if (i == 10) check("restart_not_10", link_ok, 0);
        end
        check("restart_up_11", link_ok, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
